// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit controllers.
// Holds the receive FSM encoding and common widths/limits.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARM       = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_RECEIVING = 2'd3
    } rx_ctrl_state_t;

    localparam int DW_DEF      = 8;
    localparam int ERR_CNT_MAX = 255;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with first-word fall-through head and level output.
// Push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int DW    = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    localparam int AW = LW - 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [LW-1:0] wr_q, rd_q, wr_d, rd_d;
    logic          pop_ok, push_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_o   = wr_q - rd_q;
    assign full_o    = (level_o == LW'(DEPTH));
    assign empty_o   = (level_o == '0);
    assign pop_ok    = pop_i & ~empty_o;
    assign push_ok   = push_i & (~full_o | pop_ok);
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q + LW'(push_ok);
        rd_d = rd_q + LW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the UART receiver (arm, wait, capture) and queues good bytes for the register block.
// Tracks parity/framing errors and overruns; rx_done to byte on pop_data is one cycle.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int DW       = DW_DEF,
    parameter  int START_TO = 64,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          ctrl_en,
    input  logic [LW-1:0] irq_thresh,
    input  logic          clr_status,
    input  logic          rx_busy,
    input  logic          rx_done,
    input  logic          rx_error,
    input  logic [DW-1:0] rx_data,
    output logic          rx_enable,
    output logic          rx_start,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [LW-1:0] fifo_level,
    output logic          overrun,
    output logic [7:0]    err_cnt,
    output logic          irq
);

    localparam int TW = $clog2(START_TO + 1);

    rx_ctrl_state_t state_q, state_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     err_q, err_d;
    logic           ovr_q, ovr_d;
    logic           irq_q, irq_d;
    logic           capture, pop_ok, push, ovr_ev, err_ev;
    logic [LW-1:0]  level_nxt;

    assign capture = rx_done & ((state_q == ST_WAIT_BUSY) | (state_q == ST_RECEIVING));
    assign pop_ok  = pop & ~fifo_empty;
    assign push    = capture & ~rx_error & (~fifo_full | pop_ok);
    assign ovr_ev  = capture & ~rx_error & fifo_full & ~pop_ok;
    assign err_ev  = capture & rx_error;

    sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk        (clk),
        .rst        (RST),
        .push_i     (push),
        .push_dat_i (rx_data),
        .pop_i      (pop),
        .pop_dat_o  (pop_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        case (state_q)
            ST_IDLE:      if (ctrl_en) state_d = ST_ARM;
            ST_ARM:       state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                // A frame may finish before busy is ever seen; treat it as received.
                if (rx_done)                         state_d = ST_ARM;
                else if (rx_busy)                    state_d = ST_RECEIVING;
                else if (tmo_q == TW'(START_TO - 1)) state_d = ST_ARM;
                else                                 tmo_d   = tmo_q + TW'(1);
            end
            ST_RECEIVING: if (rx_done) state_d = ST_ARM;
            default:      state_d = ST_IDLE;
        endcase
        if (!ctrl_en) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end
    end

    always_comb begin
        rx_enable = (state_q != ST_IDLE);
        rx_start  = (state_q == ST_ARM);
    end

    always_comb begin
        err_d = err_q;
        if (err_ev) begin
            if (clr_status)                    err_d = 8'd1;
            else if (err_q != 8'(ERR_CNT_MAX)) err_d = err_q + 8'd1;
        end else if (clr_status) begin
            err_d = '0;
        end
        ovr_d     = ovr_ev | (ovr_q & ~clr_status);
        level_nxt = fifo_level + LW'(push) - LW'(pop_ok);
        // Built from next-state values so irq tracks the status outputs it reflects.
        irq_d     = ovr_d | (err_d != '0) | ((irq_thresh != '0) & (level_nxt >= irq_thresh));
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            err_q <= '0;
            ovr_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            err_q <= err_d;
            ovr_q <= ovr_d;
            irq_q <= irq_d;
        end
    end

    assign err_cnt = err_q;
    assign overrun = ovr_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized self-checking bench for uart_rx_ctrl against a queue-based behavioural model.
module tb_uart_rx_ctrl;

    localparam int DEPTH    = 8;
    localparam int DW       = 8;
    localparam int START_TO = 64;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          RST, ctrl_en, clr_status, rx_busy, rx_done, rx_error, pop;
    logic [LW-1:0] irq_thresh;
    logic [DW-1:0] rx_data;
    logic          rx_enable, rx_start, fifo_empty, fifo_full, overrun, irq;
    logic [DW-1:0] pop_data;
    logic [LW-1:0] fifo_level;
    logic [7:0]    err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mq[$];
    int         merr;
    logic       movr;
    logic [7:0] last_pop;

    uart_rx_ctrl #(.DEPTH(DEPTH), .DW(DW), .START_TO(START_TO)) dut (
        .clk(clk), .RST(RST), .ctrl_en(ctrl_en), .irq_thresh(irq_thresh),
        .clr_status(clr_status), .rx_busy(rx_busy), .rx_done(rx_done),
        .rx_error(rx_error), .rx_data(rx_data), .rx_enable(rx_enable),
        .rx_start(rx_start), .pop(pop), .pop_data(pop_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .overrun(overrun), .err_cnt(err_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_irq();
        return movr | (merr != 0) | ((irq_thresh != 0) && (mq.size() >= int'(irq_thresh)));
    endfunction

    // Runs one receiver frame from the next rx_start pulse and applies the frame to the model.
    task automatic do_frame(input logic [7:0] d, input logic e, input logic p, input logic c);
        int   n = 0;
        int   sz;
        logic popped = 1'b0;
        while (rx_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL frame_arm_timeout: rx_start=%b after %0d cycles, required 1", rx_start, n);
        end
        rx_busy = 1'b1;
        tick();
        tick();
        rx_done = 1'b1; rx_data = d; rx_error = e; pop = p; clr_status = c;
        sz = mq.size();
        if (p && sz > 0) begin
            last_pop = mq.pop_front();
            popped = 1'b1;
        end
        if (c) merr = 0;
        if (c) movr = 1'b0;
        if (e) begin
            if (merr < 255) merr++;
        end else if (sz < DEPTH || popped) begin
            mq.push_back(d);
        end else begin
            movr = 1'b1;
        end
        tick();
        rx_done = 1'b0; rx_error = 1'b0; pop = 1'b0; clr_status = 1'b0; rx_busy = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        if (mq.size() > 0) last_pop = mq.pop_front();
        tick();
        pop = 1'b0;
    endtask

    task automatic do_clr();
        clr_status = 1'b1;
        merr = 0;
        movr = 1'b0;
        tick();
        clr_status = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; ctrl_en = 1'b0; clr_status = 1'b0; rx_busy = 1'b0; rx_done = 1'b0;
        rx_error = 1'b0; rx_data = '0; pop = 1'b0; irq_thresh = '0;
        tick(); tick();
        RST = 1'b0;
        mq.delete(); merr = 0; movr = 1'b0;
        n_checks++; if (rx_enable !== 1'b0) $display("FAIL reset_rx_enable: got %b want 0", rx_enable); else n_pass++;
        n_checks++; if (rx_start !== 1'b0) $display("FAIL reset_rx_start: got %b want 0", rx_start); else n_pass++;
        n_checks++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", fifo_empty); else n_pass++;
        n_checks++; if (fifo_level !== '0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (pop_data !== '0) $display("FAIL reset_pop_data: got %h want 00", pop_data); else n_pass++;
        n_checks++; if ({overrun, err_cnt, irq, fifo_full} !== '0)
            $display("FAIL reset_status: got ovr=%b err=%0d irq=%b full=%b want all 0", overrun, err_cnt, irq, fifo_full);
        else n_pass++;
    endtask

    task automatic test_basic();
        ctrl_en = 1'b1;
        tick();
        n_checks++; if ({rx_start, rx_enable} !== 2'b11) $display("FAIL basic_arm: got start=%b en=%b want 1 1", rx_start, rx_enable); else n_pass++;
        rx_busy = 1'b1;
        tick();
        n_checks++; if (rx_start !== 1'b0) $display("FAIL basic_single_start: got %b want 0", rx_start); else n_pass++;
        tick();
        rx_done = 1'b1; rx_data = 8'hA5;
        mq.push_back(8'hA5);
        tick();
        rx_done = 1'b0; rx_busy = 1'b0;
        n_checks++; if (pop_data !== 8'hA5) $display("FAIL basic_pop_data: got %h want a5", pop_data); else n_pass++;
        n_checks++; if (fifo_level !== LW'(1) || fifo_empty !== 1'b0)
            $display("FAIL basic_level: got lvl=%0d empty=%b want 1 0", fifo_level, fifo_empty);
        else n_pass++;
        n_checks++; if (rx_start !== 1'b1) $display("FAIL basic_rearm: got %b want 1", rx_start); else n_pass++;
        do_pop();
        n_checks++; if (fifo_empty !== 1'b1) $display("FAIL basic_pop_empty: got %b want 1", fifo_empty); else n_pass++;
    endtask

    task automatic test_errors();
        for (int i = 0; i < 3; i++) do_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        n_checks++; if (err_cnt !== 8'd3) $display("FAIL err_count3: got %0d want 3", err_cnt); else n_pass++;
        n_checks++; if (fifo_level !== '0) $display("FAIL err_level: got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL err_irq: got %b want 1", irq); else n_pass++;
        do_clr();
        n_checks++; if ({err_cnt, irq} !== 9'd0) $display("FAIL err_clear: got err=%0d irq=%b want 0 0", err_cnt, irq); else n_pass++;
        for (int i = 0; i < 258; i++) do_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        n_checks++; if (int'(err_cnt) !== merr) $display("FAIL err_saturate: got %0d want %0d", err_cnt, merr); else n_pass++;
        do_frame(8'($urandom), 1'b1, 1'b0, 1'b1);
        n_checks++; if (int'(err_cnt) !== merr) $display("FAIL err_clr_collide: got %0d want %0d", err_cnt, merr); else n_pass++;
        do_clr();
    endtask

    task automatic test_overrun();
        logic [7:0] ninth;
        for (int i = 0; i < DEPTH; i++) do_frame(8'(i + 1), 1'b0, 1'b0, 1'b0);
        n_checks++; if (fifo_full !== 1'b1) $display("FAIL ovr_full: got %b want 1", fifo_full); else n_pass++;
        do_frame(8'h09, 1'b0, 1'b0, 1'b0);
        n_checks++; if (overrun !== movr) $display("FAIL ovr_flag: got %b want %b", overrun, movr); else n_pass++;
        n_checks++; if (int'(fifo_level) !== mq.size()) $display("FAIL ovr_level: got %0d want %0d", fifo_level, mq.size()); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (pop_data !== mq[0]) $display("FAIL ovr_order%0d: got %h want %h", i, pop_data, mq[0]); else n_pass++;
            do_pop();
        end
        do_clr();
        for (int i = 0; i < DEPTH; i++) do_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        ninth = 8'($urandom);
        do_frame(ninth, 1'b0, 1'b1, 1'b0);
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_pop_same_cycle: got %b want 0", overrun); else n_pass++;
        while (mq.size() > 1) do_pop();
        n_checks++; if (pop_data !== ninth) $display("FAIL ovr_last_byte: got %h want %h", pop_data, ninth); else n_pass++;
        do_pop();
    endtask

    task automatic test_timeout();
        int n = 0;
        while (rx_start !== 1'b1 && n < 300) begin tick(); n++; end
        for (int k = 0; k < 2; k++) begin
            n = 0;
            tick(); n++;
            while (rx_start !== 1'b1 && n < 300) begin tick(); n++; end
            n_checks++; if (n !== START_TO + 1) $display("FAIL timeout_period%0d: got %0d cycles want %0d", k, n, START_TO + 1); else n_pass++;
        end
        rx_busy = 1'b1;
        tick(); tick();
        ctrl_en = 1'b0;
        tick();
        n_checks++; if (rx_enable !== 1'b0) $display("FAIL abort_enable: got %b want 0", rx_enable); else n_pass++;
        rx_done = 1'b1; rx_data = 8'($urandom);
        tick();
        rx_done = 1'b0; rx_busy = 1'b0;
        n_checks++; if (int'(fifo_level) !== mq.size() || rx_start !== 1'b0)
            $display("FAIL abort_no_push: got lvl=%0d start=%b want %0d 0", fifo_level, rx_start, mq.size());
        else n_pass++;
        ctrl_en = 1'b1;
    endtask

    task automatic test_irq_thresh();
        irq_thresh = LW'(4);
        for (int i = 0; i < 3; i++) do_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0) $display("FAIL thr_below: got %b want 0", irq); else n_pass++;
        do_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b1) $display("FAIL thr_reached: got %b want 1", irq); else n_pass++;
        do_pop();
        n_checks++; if (irq !== 1'b0) $display("FAIL thr_after_pop: got %b want 0", irq); else n_pass++;
        while (mq.size() > 0) do_pop();
        do_pop();
        n_checks++; if (fifo_level !== '0 || fifo_empty !== 1'b1)
            $display("FAIL pop_empty: got lvl=%0d empty=%b want 0 1", fifo_level, fifo_empty);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       e, p;
        irq_thresh = LW'($urandom_range(1, DEPTH));
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            e = ($urandom_range(0, 4) == 0);
            p = ($urandom_range(0, 2) == 0);
            if (p && mq.size() > 0) begin
                n_checks++; if (pop_data !== mq[0]) $display("FAIL rnd_head%0d: got %h want %h", i, pop_data, mq[0]); else n_pass++;
            end
            do_frame(d, e, p, 1'b0);
            n_checks++;
            if (int'(fifo_level) !== mq.size() || int'(err_cnt) !== merr || overrun !== movr || irq !== exp_irq())
                $display("FAIL rnd_state%0d: got lvl=%0d err=%0d ovr=%b irq=%b want %0d %0d %b %b",
                         i, fifo_level, err_cnt, overrun, irq, mq.size(), merr, movr, exp_irq());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_clr();
        irq_thresh = '0;
        while (mq.size() > 0) do_pop();
        do_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        do_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        do_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        rx_busy = 1'b1;
        tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; rx_busy = 1'b0;
        mq.delete(); merr = 0; movr = 1'b0;
        n_checks++; if (fifo_level !== '0 || fifo_empty !== 1'b1)
            $display("FAIL rstmid_level: got lvl=%0d empty=%b want 0 1", fifo_level, fifo_empty);
        else n_pass++;
        n_checks++; if ({overrun, err_cnt} !== 9'd0) $display("FAIL rstmid_status: got ovr=%b err=%0d want 0 0", overrun, err_cnt); else n_pass++;
        n_checks++; if ({rx_start, rx_enable} !== 2'b00) $display("FAIL rstmid_idle: got start=%b en=%b want 0 0", rx_start, rx_enable); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_overrun();
        test_timeout();
        test_irq_thresh();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequencing controller for the UART receiver datapath: arms the receiver, waits for each frame, and captures good bytes into a FIFO.
- Counts parity/framing errors and flags overruns.
- Presents a pop/status interface to the APB register block, so software never handles receiver handshakes directly.
- Sits between UART_Receiver and the APB slave wrapper in the UART subsystem.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DW, 8, data width; matches receiver out.
- START_TO, 64, cycles to wait for rx_busy after a start pulse before re-arming.
- LW, $clog2(DEPTH)+1, width of level fields (derived, not overridden).

Ports:
- clk  in  1  system clock
- RST  in  1  synchronous active-high reset
- ctrl_en  in  1  software enable for reception
- irq_thresh  in  LW  FIFO level that raises irq; 0 disables the level interrupt
- clr_status  in  1  one-cycle pulse that clears overrun and err_cnt
- rx_busy  in  1  from receiver
- rx_done  in  1  from receiver, one-cycle pulse at frame end
- rx_error  in  1  from receiver, valid with rx_done
- rx_data  in  DW  from receiver, valid with rx_done
- rx_enable  out  1  to receiver enable
- rx_start  out  1  to receiver RX_start, one-cycle pulse
- pop  in  1  consume FIFO head
- pop_data  out  DW  FIFO head, first-word fall-through
- fifo_empty  out  1
- fifo_full  out  1
- fifo_level  out  LW  entries held, 0..DEPTH
- overrun  out  1  sticky
- err_cnt  out  8  saturating error count
- irq  out  1

Behaviour:
- One clock, clk. RST is synchronous and active-high.
- On RST:
  - All outputs are 0 and the FSM is IDLE.
  - FIFO pointers are cleared (fifo_empty=1, level=0) and the timeout counter is 0.
  - pop_data is 0.
- FSM states: IDLE, ARM, WAIT_BUSY, RECEIVING.
  - IDLE: rx_enable=0. ctrl_en=1 → ARM next cycle.
  - ARM: rx_enable=1, rx_start=1 for exactly this one cycle → WAIT_BUSY.
  - WAIT_BUSY:
    - rx_busy=1 → RECEIVING.
    - rx_done in this state is treated as in RECEIVING.
    - Counter reaches START_TO-1 with no busy → ARM (re-pulse start).
  - RECEIVING: on rx_done → ARM. The next frame is armed the cycle after done.
  - Any state with ctrl_en=0 → IDLE next cycle and rx_enable drops. An in-flight frame is abandoned; rx_done seen in IDLE or ARM is ignored.
- Capture, evaluated in the rx_done cycle in WAIT_BUSY or RECEIVING:
  - rx_error=1: byte discarded; err_cnt increments, saturating at 255.
  - rx_error=0 and FIFO not full, or full with pop in the same cycle: rx_data is pushed. It is visible on pop_data/level the next cycle.
  - rx_error=0, FIFO full, no pop: byte dropped, overrun←1.
- The controller keeps arming while the FIFO is full, because line data arrives regardless.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - pop while empty is ignored; no level underflow.
  - Simultaneous push and pop when empty: push occurs, pop ignored.
  - Simultaneous push and pop otherwise: level unchanged.
- clr_status clears overrun and err_cnt next cycle.
  - clr_status together with a new error or overrun event: the event wins (counter =1, overrun=1).
- irq is registered: irq = overrun | (err_cnt≠0) | (irq_thresh≠0 & fifo_level≥irq_thresh).
- Latency: rx_done → byte readable on pop_data is 1 cycle.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (rx_ctrl_state_t).
  - DW default.
  - ERR_CNT_MAX=255.
- One natural sub-module: sync_fifo (DEPTH, DW; push/pop/full/empty/level, first-word fall-through). It is reusable by the future TX controller.

Test Plan:
- Reset then ctrl_en=1 → rx_start pulses once; busy raised and rx_done with data 0xA5 and error=0 → pop_data=0xA5, level=1, fifo_empty=0 one cycle later; a new rx_start follows the cycle after done.
- rx_done with error=1 three times → err_cnt=3, FIFO level stays 0, irq=1; clr_status → err_cnt=0, irq=0 next cycle.
- DEPTH=8: push 8 good bytes 0x01..0x08 → fifo_full=1; 9th byte 0x09 without pop → overrun=1, level=8, bytes pop in order 0x01..0x08; 9th byte with simultaneous pop → overrun stays 0, last popped is 0x09.
- rx_busy never asserted → rx_start re-pulses every START_TO+1 cycles (ARM, then START_TO cycles in WAIT_BUSY); ctrl_en=0 mid-RECEIVING then rx_done → no push, rx_enable=0.
- irq_thresh=4: 3 bytes → irq=0; 4th → irq=1; one pop → irq=0; pop while empty → level stays 0.
- RST asserted mid-frame with 2 bytes queued → next cycle level=0, overrun=0, err_cnt=0, FSM IDLE, rx_start=0.
